// File: rtl/bm_sincos_ctrl_if.sv
// ---------------------------------------------------------------------------
// bm_sincos_ctrl_if
//   Bundles every non-clock signal of the Box-Muller sin/cos sequencer:
//   the u1 input stream, the datapath hookup, the reconstructed output
//   stream and the status outputs.
//
//   slave  : controller side (bm_sincos_ctrl)
//   master : environment side (source, datapath, sink)
//
//   flush       synchronous discard of in-flight tags and FIFO contents
//   in_*        u1 sample stream, valid/ready
//   dp_u1       u1 towards the datapath (quadrant bits forced to 00)
//   dp_g0/g1    quadrant-0 results returning from the datapath
//   out_*       reconstructed (g0, g1) stream, valid/ready
//   busy        any sample in flight or buffered
//   sample_cnt  pairs delivered since reset/flush
// ---------------------------------------------------------------------------
interface bm_sincos_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_u1;
    logic [15:0]      dp_u1;
    logic [15:0]      dp_g0;
    logic [15:0]      dp_g1;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_g0;
    logic [15:0]      out_g1;
    logic             busy;
    logic [CNT_W-1:0] sample_cnt;

    modport slave (
        input  flush, in_valid, in_u1, dp_g0, dp_g1, out_ready,
        output in_ready, dp_u1, out_valid, out_g0, out_g1, busy, sample_cnt
    );

    modport master (
        output flush, in_valid, in_u1, dp_g0, dp_g1, out_ready,
        input  in_ready, dp_u1, out_valid, out_g0, out_g1, busy, sample_cnt
    );
endinterface

// File: rtl/bm_sincos_ctrl.sv
// ---------------------------------------------------------------------------
// bm_sincos_ctrl
//   Streaming sequencer for the Box-Muller sin/cos datapath. Accepts u1
//   samples, sends only the angle fraction into the fixed-latency datapath,
//   carries each sample's quadrant alongside it in a tag pipe, rebuilds the
//   full-circle (g0, g1) pair on return and buffers it in an output FIFO.
//   Input acceptance is credit-limited so a returning result always has a
//   FIFO slot, whatever the downstream backpressure.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      bm_sincos_ctrl_if.slave (see interface header)
//
//   Parameters:
//     DP_LATENCY  datapath latency in cycles from dp_u1 update (>=1)
//     FIFO_DEPTH  output FIFO entries (power of two, >=1)
//     CNT_W       width of the delivered-pair counter
// ---------------------------------------------------------------------------
module bm_sincos_ctrl #(
    parameter int DP_LATENCY = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    bm_sincos_ctrl_if.slave bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int UW = 16;    // width of the credit arithmetic

    typedef struct packed {
        logic [15:0] g0;
        logic [15:0] g1;
    } pair_t;

    // vld_pipe[0] is loaded with the issue strobe at the issue edge; the
    // datapath result for that sample is on dp_g0/dp_g1 while the tag sits
    // in vld_pipe[DP_LATENCY], and it enters the FIFO on the following edge.
    logic [DP_LATENCY:0]      vld_pipe;
    logic [DP_LATENCY:0][1:0] quad_pipe;

    logic                     run;       // low during and just after reset
    logic [15:0]              dp_u1_q;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            fifo_cnt;
    logic [CNT_W-1:0]         cnt_q;
    pair_t                    mem [FIFO_DEPTH];
    pair_t                    head;

    logic [UW-1:0]            inflight;
    logic                     issue;
    logic                     capture;
    logic                     push;
    logic                     pop;

    logic [1:0]               cap_q;
    logic                     swap;
    logic [15:0]              sel0;
    logic [15:0]              sel1;
    pair_t                    rec;

    function automatic logic [15:0] neg_sat(input logic [15:0] x);
        // the only unrepresentable negation is -(-32768)
        return (x == 16'h8000) ? 16'h7fff : (~x + 16'd1);
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // ---------------- credit / handshake ----------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= DP_LATENCY; i++)
            inflight = inflight + UW'(vld_pipe[i]);
    end

    // Every tag in flight already owns a FIFO slot, so acceptance only
    // needs the sum of in-flight and buffered samples to be below depth.
    assign bus.in_ready  = run & ~bus.flush &
                           ((inflight + UW'(fifo_cnt)) < UW'(FIFO_DEPTH));
    assign issue         = bus.in_valid & bus.in_ready;
    assign capture       = vld_pipe[DP_LATENCY];
    assign push          = capture & ~bus.flush;
    assign bus.out_valid = (fifo_cnt != '0);
    assign pop           = bus.out_valid & bus.out_ready & ~bus.flush;

    // ---------------- range reconstruction ----------------
    // a = dp_g1, b = dp_g0. Quadrant 0 passes (b, a) straight; every other
    // quadrant presents (a, b) with sign flips: g0 negated in q2/q3,
    // g1 negated in q1/q2.
    always_comb begin
        cap_q  = quad_pipe[DP_LATENCY];
        swap   = (cap_q != 2'd0);
        sel0   = swap ? bus.dp_g1 : bus.dp_g0;
        sel1   = swap ? bus.dp_g0 : bus.dp_g1;
        rec.g0 = cap_q[1] ? neg_sat(sel0) : sel0;
        rec.g1 = (cap_q[1] ^ cap_q[0]) ? neg_sat(sel1) : sel1;
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            vld_pipe  <= '0;
            quad_pipe <= '0;
            dp_u1_q   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            cnt_q     <= '0;
        end else begin
            run       <= 1'b1;
            // quadrant stays with the controller; the datapath only ever
            // sees quadrant 0
            if (issue)
                dp_u1_q <= {2'b00, bus.in_u1[13:0]};
            quad_pipe <= {quad_pipe[DP_LATENCY-1:0], bus.in_u1[15:14]};

            if (bus.flush) begin
                vld_pipe <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                cnt_q    <= '0;
            end else begin
                vld_pipe <= {vld_pipe[DP_LATENCY-1:0], issue};
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                    default: fifo_cnt <= fifo_cnt;
                endcase
                if (pop)
                    cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // FIFO storage carries no reset; an entry is only visible once counted
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rec;
    end

    assign head           = mem[rd_ptr];
    assign bus.out_g0     = bus.out_valid ? head.g0 : 16'h0000;
    assign bus.out_g1     = bus.out_valid ? head.g1 : 16'h0000;
    assign bus.dp_u1      = dp_u1_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.busy       = (inflight != '0) | (fifo_cnt != '0);

endmodule

// File: tb/tb_bm_sincos_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bm_sincos_ctrl
//   Two controllers (FIFO_DEPTH 4 and 8, DP_LATENCY 4) each driven through
//   its own interface and fed by a 4-stage datapath stub. A per-instance
//   reference model keeps a queue of expected pairs computed from the
//   quadrant table and compares every delivered pair in order.
// ---------------------------------------------------------------------------
module tb_bm_sincos_ctrl;

    localparam int DPL   = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic             iv   [2];
    logic [15:0]      iu   [2];
    logic             ordy [2];
    logic             fl   [2];
    logic             ir   [2];
    logic             ov   [2];
    logic [15:0]      og0  [2];
    logic [15:0]      og1  [2];
    logic [15:0]      du   [2];
    logic             bsy  [2];
    logic [CNT_W-1:0] scnt [2];
    int               msz  [2];

    logic             stub_const;
    logic [15:0]      c_g0;
    logic [15:0]      c_g1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // datapath stub transfer functions (quadrant-0 results)
    function automatic logic [15:0] f_g0(input logic [15:0] u);
        return {u[13:0], 2'b00} ^ 16'h8000;
    endfunction
    function automatic logic [15:0] f_g1(input logic [15:0] u);
        return {u[15:14] ^ 2'b10, u[13:0]};
    endfunction

    function automatic logic [15:0] nsat(input logic [15:0] x);
        return (x == 16'h8000) ? 16'h7FFF : (16'h0000 - x);
    endfunction

    // expected {g0, g1} for an accepted sample
    function automatic logic [31:0] expect_pair(input logic [15:0] u);
        logic [15:0] uq, a, b;
        uq = {2'b00, u[13:0]};
        a  = stub_const ? c_g1 : f_g1(uq);
        b  = stub_const ? c_g0 : f_g0(uq);
        case (u[15:14])
            2'd0:    return {b, a};
            2'd1:    return {a, nsat(b)};
            2'd2:    return {nsat(a), nsat(b)};
            default: return {nsat(a), b};
        endcase
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g
        localparam int D = (i == 0) ? 4 : 8;

        bm_sincos_ctrl_if #(.CNT_W(CNT_W)) bus ();

        bm_sincos_ctrl #(.DP_LATENCY(DPL), .FIFO_DEPTH(D), .CNT_W(CNT_W)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );

        assign bus.flush     = fl[i];
        assign bus.in_valid  = iv[i];
        assign bus.in_u1     = iu[i];
        assign bus.out_ready = ordy[i];
        assign ir[i]   = bus.in_ready;
        assign ov[i]   = bus.out_valid;
        assign og0[i]  = bus.out_g0;
        assign og1[i]  = bus.out_g1;
        assign du[i]   = bus.dp_u1;
        assign bsy[i]  = bus.busy;
        assign scnt[i] = bus.sample_cnt;

        logic [15:0] sp [DPL];
        always @(posedge clk) begin
            sp[0] <= bus.dp_u1;
            for (int j = 1; j < DPL; j++) sp[j] <= sp[j-1];
        end
        assign bus.dp_g0 = stub_const ? c_g0 : f_g0(sp[DPL-1]);
        assign bus.dp_g1 = stub_const ? c_g1 : f_g1(sp[DPL-1]);

        logic [31:0]      q [$];
        logic [CNT_W-1:0] cnt;
        always @(negedge clk) begin
            if (!reset_n || fl[i]) begin
                q.delete();
                cnt = '0;
            end else begin
                if (ov[i] && ordy[i]) begin
                    if (q.size() == 0)
                        chk($sformatf("pop_model_empty%0d", i), 32'(q.size()), 32'd1);
                    else begin
                        chk($sformatf("pair%0d", i), {og0[i], og1[i]}, q.pop_front());
                        chk($sformatf("sample_cnt%0d", i), scnt[i], cnt);
                        cnt = cnt + 1'b1;
                    end
                end
                if (iv[i] && ir[i]) begin
                    q.push_back(expect_pair(iu[i]));
                    chk($sformatf("no_overflow%0d", i), 32'(q.size() <= D), 32'd1);
                end
            end
            msz[i] = q.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [15:0] u);
        int w;
        iv[k] = 1'b1;
        iu[k] = u;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ir[k] && w < 50);
        chk("send_ready", ir[k], 1'b1);
        tick();
        iv[k] = 1'b0;
    endtask

    task automatic wait_ov(input int k);
        int w;
        w = 0;
        @(negedge clk);
        while (!ov[k] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("wait_out_valid", ov[k], 1'b1);
    endtask

    task automatic pop1(input int k);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
    endtask

    initial begin
        logic [15:0] qin  [4];
        logic [31:0] qexp [4];
        int  n, sent, pops, gaps, cyc, t_iss, t_ov;
        bit  issued;

        qin  = '{16'h0100, 16'h4100, 16'h8100, 16'hC100};
        qexp = '{32'h1234_0567, 32'h0567_EDCC, 32'hFA99_EDCC, 32'hFA99_1234};

        reset_n    = 1'b0;
        stub_const = 1'b1;
        c_g0       = 16'h0000;
        c_g1       = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b1; iu[k] = 16'hFFFF; ordy[k] = 1'b0; fl[k] = 1'b0;
        end

        // ---- reset state with in_valid held high ----
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  ir[0],   1'b0);
        chk("rst_out_valid", ov[0],   1'b0);
        chk("rst_sample_cnt", scnt[0], 32'd0);
        chk("rst_dp_u1",     du[0],   16'h0000);
        chk("rst_busy",      bsy[0],  1'b0);
        chk("rst_out_g0",    og0[0],  16'h0000);
        tick();
        iv[0] = 1'b0; iv[1] = 1'b0;
        reset_n = 1'b1;
        repeat (2) tick();

        // ---- quadrant table with constant datapath results ----
        c_g0 = 16'h1234;
        c_g1 = 16'h0567;
        for (int i = 0; i < 4; i++) begin
            send(0, qin[i]);
            chk("quad_dp_u1", du[0], 16'h0100);
        end
        for (int i = 0; i < 4; i++) begin
            wait_ov(0);
            chk("quad_g0", og0[0], qexp[i][31:16]);
            chk("quad_g1", og1[0], qexp[i][15:0]);
            pop1(0);
        end

        // ---- saturation of the 0x8000 negation ----
        c_g0 = 16'h8000;
        c_g1 = 16'h8000;
        send(0, 16'h4123);
        send(0, 16'h8123);
        wait_ov(0);
        chk("busy_with_data", bsy[0], 1'b1);
        chk("sat_q1_g1", og1[0], 16'h7FFF);
        pop1(0);
        wait_ov(0);
        chk("sat_q2_g0", og0[0], 16'h7FFF);
        pop1(0);
        repeat (2) tick();
        chk("idle_busy", bsy[0], 1'b0);

        // ---- backpressure on the depth-4 instance ----
        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        chk("flush_cnt0", scnt[0], 32'd0);
        stub_const = 1'b0;
        iv[0] = 1'b1;
        iu[0] = 16'($urandom);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            issued = ir[0];
            if (issued) n++;
            tick();
            if (issued) iu[0] = 16'($urandom);
        end
        chk("bp_issues", n, 4);
        chk("bp_in_ready", ir[0], 1'b0);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov[0]) n++;
        end
        ordy[0] = 1'b0;
        chk("bp_pops", n, 4);
        chk("bp_sample_cnt", scnt[0], 32'd4);
        chk("bp_busy", bsy[0], 1'b0);

        // ---- streaming on the depth-8 instance ----
        tick();
        iv[1] = 1'b1; iu[1] = 16'($urandom); ordy[1] = 1'b1;
        sent = 0; pops = 0; gaps = 0; cyc = 0; t_iss = -1; t_ov = -1;
        while (pops < 100 && cyc < 400) begin
            @(negedge clk);
            issued = iv[1] && ir[1];
            if (issued) begin
                if (t_iss < 0) t_iss = cyc;
                sent++;
            end
            if (ov[1]) begin
                if (t_ov < 0) t_ov = cyc;
                pops++;
            end else if (t_ov >= 0) gaps++;
            tick();
            cyc++;
            if (issued) begin
                if (sent == 100) iv[1] = 1'b0;
                else             iu[1] = 16'($urandom);
            end
        end
        // issue observed at cycle t_iss lands on the following edge
        chk("stream_latency", 32'(t_ov - t_iss - 1), 32'd5);
        chk("stream_sent", sent, 100);
        chk("stream_pops", pops, 100);
        chk("stream_gaps", gaps, 0);
        @(negedge clk);
        chk("stream_cnt", scnt[1], 32'd100);

        // ---- flush with 2 buffered and 3 in flight ----
        ordy[1] = 1'b0;
        tick();
        send(1, 16'($urandom));
        send(1, 16'($urandom));
        repeat (8) tick();
        iv[1] = 1'b1;
        iu[1] = 16'($urandom);
        n = 0;
        while (n < 3) begin
            @(negedge clk);
            issued = ir[1];
            if (issued) n++;
            tick();
            if (issued) iu[1] = 16'($urandom);
        end
        iv[1] = 1'b0;
        chk("pre_flush_busy", bsy[1], 1'b1);
        fl[1] = 1'b1;
        tick();
        fl[1] = 1'b0;
        chk("flush_out_valid", ov[1], 1'b0);
        chk("flush_busy", bsy[1], 1'b0);
        chk("flush_cnt", scnt[1], 32'd0);
        ordy[1] = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ov[1]) n++;
        end
        chk("flush_no_stale", n, 0);

        // ---- randomized traffic on both instances ----
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(9) < 6);
                iu[k]   = 16'($urandom);
                if ($urandom_range(7) == 0) iu[k][13:0] = '0;
                ordy[k] = ($urandom_range(9) < 7);
                fl[k]   = ($urandom_range(79) == 0);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((msz[0] != 0 || msz[1] != 0) && n < 60);
        @(negedge clk);
        chk("drain0", msz[0], 0);
        chk("drain1", msz[1], 0);
        chk("drain_busy0", bsy[0], 1'b0);

        // ---- reset in the middle of traffic ----
        ordy[0] = 1'b0;
        send(0, 16'h5555);
        send(0, 16'hAAAA);
        repeat (6) tick();
        chk("pre_reset_valid", ov[0], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov[0], 1'b0);
        chk("midrst_busy", bsy[0], 1'b0);
        chk("midrst_out_g0", og0[0], 16'h0000);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
